// File: rtl/timer_sched_pkg.sv
// Shared definitions for the timer scheduler: command opcodes, channel state
// encoding and elaboration-time sizing helpers.
package timer_sched_pkg;

  localparam logic CMD_ARM  = 1'b0;
  localparam logic CMD_STOP = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ch_state_e;

  function automatic int unsigned calc_div(input int unsigned f0, input int unsigned f1);
    return f0 / f1;
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/timer_sched_tick_gen.sv
// Free-running prescaler: one-cycle tick every F0/F1 clocks, first tick
// DIV clocks after reset release.
module tick_gen
  import timer_sched_pkg::*;
#(
  parameter int unsigned F0 = 50_000_000,
  parameter int unsigned F1 = 1_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned DIV = calc_div(F0, F1);
  localparam int unsigned PW  = idx_w(DIV);

  logic [PW-1:0] pcnt_q, pcnt_d;

  assign tick = (pcnt_q == PW'(DIV - 1));

  always_comb begin
    pcnt_d = tick ? '0 : pcnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/timer_sched.sv
// Multi-channel countdown timer scheduler with a round-robin event port.
// Define TIMER_SCHED_OVR_EN to enable sticky per-channel overrun flags.
module timer_sched
  import timer_sched_pkg::*;
#(
  parameter int unsigned F0    = 50_000_000,
  parameter int unsigned F1    = 1_000,
  parameter int unsigned N_CH  = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  input  logic                   cmd_op,
  input  logic [idx_w(N_CH)-1:0] cmd_ch,
  input  logic [CNT_W-1:0]       cmd_load,
  input  logic                   cmd_periodic,
  output logic                   cmd_err,
  output logic [N_CH-1:0]        busy,
  output logic [N_CH-1:0]        ovr,
  output logic                   evt_valid,
  output logic [idx_w(N_CH)-1:0] evt_ch,
  input  logic                   evt_ready
);

  localparam int unsigned CH_W = idx_w(N_CH);

  logic tick;

  ch_state_e        state_q [N_CH];
  ch_state_e        state_d [N_CH];
  logic [CNT_W-1:0] cnt_q   [N_CH];
  logic [CNT_W-1:0] cnt_d   [N_CH];
  logic [CNT_W-1:0] load_q  [N_CH];
  logic [CNT_W-1:0] load_d  [N_CH];
  logic [N_CH-1:0]  per_q, per_d;
  logic [N_CH-1:0]  pend_q, pend_d;
  logic [N_CH-1:0]  cmd_sel, acc_sel, held_sel;
  logic             arm_ok, stop_ok;
  logic             cmd_err_q, cmd_err_d;
  logic             evt_valid_q, evt_valid_d;
  logic [CH_W-1:0]  evt_ch_q, evt_ch_d;
  logic [CH_W-1:0]  rr_q, rr_d;
  logic             found;
  int unsigned      scan;
`ifdef TIMER_SCHED_OVR_EN
  logic [N_CH-1:0]  ovr_q, ovr_d;
`endif

  tick_gen #(
    .F0 (F0),
    .F1 (F1)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign arm_ok    = (cmd_op == CMD_ARM) && (cmd_load != '0);
  assign stop_ok   = (cmd_op == CMD_STOP);
  assign cmd_err_d = cmd_valid && (cmd_op == CMD_ARM) && (cmd_load == '0);

  for (genvar g = 0; g < N_CH; g++) begin : g_dec
    assign cmd_sel[g]  = cmd_valid && (cmd_ch == CH_W'(g));
    assign held_sel[g] = evt_valid_q && (evt_ch_q == CH_W'(g));
    assign acc_sel[g]  = held_sel[g] && evt_ready;
    assign busy[g]     = (state_q[g] == ST_RUN);
  end

  // A command on a channel pre-empts that channel's tick; expiry re-sets
  // pending after an acceptance in the same cycle, so the event is not lost.
  always_comb begin
    per_d  = per_q;
    pend_d = pend_q;
`ifdef TIMER_SCHED_OVR_EN
    ovr_d  = ovr_q;
`endif
    for (int unsigned i = 0; i < N_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      load_d[i]  = load_q[i];
      if (acc_sel[i]) pend_d[i] = 1'b0;
      if (cmd_sel[i] && arm_ok) begin
        state_d[i] = ST_RUN;
        cnt_d[i]   = cmd_load;
        load_d[i]  = cmd_load;
        per_d[i]   = cmd_periodic;
      end else if (cmd_sel[i] && stop_ok) begin
        state_d[i] = ST_IDLE;
        cnt_d[i]   = '0;
        if (!held_sel[i]) pend_d[i] = 1'b0;
`ifdef TIMER_SCHED_OVR_EN
        ovr_d[i] = 1'b0;
`endif
      end else if ((state_q[i] == ST_RUN) && tick) begin
        if (cnt_q[i] != CNT_W'(1)) begin
          cnt_d[i] = cnt_q[i] - 1'b1;
        end else begin
          pend_d[i] = 1'b1;
`ifdef TIMER_SCHED_OVR_EN
          if (pend_q[i] && !acc_sel[i]) ovr_d[i] = 1'b1;
`endif
          if (per_q[i]) begin
            cnt_d[i] = load_q[i];
          end else begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = '0;
          end
        end
      end
    end
  end

  // Selection is only made while nothing is held, so the presented event is
  // stable until accepted and there is a one-cycle gap after each acceptance.
  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_ch_d    = evt_ch_q;
    rr_d        = rr_q;
    found       = 1'b0;
    scan        = 0;
    if (evt_valid_q) begin
      if (evt_ready) begin
        evt_valid_d = 1'b0;
        rr_d        = (evt_ch_q == CH_W'(N_CH - 1)) ? '0 : evt_ch_q + 1'b1;
      end
    end else begin
      for (int unsigned k = 0; k < N_CH; k++) begin
        scan = (32'(rr_q) + k) % N_CH;
        if (!found && pend_q[CH_W'(scan)]) begin
          found       = 1'b1;
          evt_valid_d = 1'b1;
          evt_ch_d    = CH_W'(scan);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
        load_q[i]  <= '0;
      end
      per_q       <= '0;
      pend_q      <= '0;
      cmd_err_q   <= 1'b0;
      evt_valid_q <= 1'b0;
      evt_ch_q    <= '0;
      rr_q        <= '0;
    end else begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        load_q[i]  <= load_d[i];
      end
      per_q       <= per_d;
      pend_q      <= pend_d;
      cmd_err_q   <= cmd_err_d;
      evt_valid_q <= evt_valid_d;
      evt_ch_q    <= evt_ch_d;
      rr_q        <= rr_d;
    end
  end

`ifdef TIMER_SCHED_OVR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_q <= '0;
    end else begin
      ovr_q <= ovr_d;
    end
  end

  assign ovr = ovr_q;
`else
  assign ovr = '0;
`endif

  assign cmd_err   = cmd_err_q;
  assign evt_valid = evt_valid_q;
  assign evt_ch    = evt_ch_q;

endmodule
